// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the modulo-N event counter family.
package cnt_pkg;

   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DN    = 1'b1;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Out-of-range load values clamp to the top of the count range.
   function automatic int unsigned ld_clamp(input int unsigned v, input int unsigned modulus);
      return (v >= modulus) ? (modulus - 1) : v;
   endfunction

endpackage

// File: rtl/dffn_r.sv
// Falling-edge D register with synchronous active-low reset to RST_VAL.
module dffn_r #(
   parameter int unsigned           WIDTH   = 1,
   parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(negedge ck) begin
      if (!rst_n) q <= RST_VAL;
      else        q <= d;
   end

endmodule

// File: rtl/ones_cnt_modn.sv
// Modulo-N up/down event counter with Mealy terminal output b, registered
// terminal pulse tc and threshold flag thr_hit; all state on the falling edge.
module ones_cnt_modn
   import cnt_pkg::*;
#(
   parameter int unsigned WIDTH   = 2,
   parameter int unsigned MODULUS = 4,
   parameter int unsigned THRESH  = 2
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             a,
   input  logic             dir,
   input  logic             sat,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] q,
   output logic             b,
   output logic             tc,
   output logic             thr_hit
);

   localparam logic [WIDTH-1:0] QMAX    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] QTHR    = WIDTH'(THRESH);
   localparam logic             THR_RST = (THRESH == 0) ? 1'b1 : 1'b0;

   if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("ones_cnt_modn: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end
   if (THRESH >= MODULUS) begin : g_bad_thresh
      $error("ones_cnt_modn: THRESH must be below MODULUS");
   end

   logic             term;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] q_ld;
   logic [WIDTH-1:0] q_nxt;
   logic             thr_nxt;

   // Terminal: about to leave the range in the current direction.
   assign term = (dir == DIR_UP) ? (q == QMAX) : (q == '0);

   assign b = a & rst_n & ~clr & ~ld & term;

   assign q_step = term ? ((sat == MODE_SAT) ? q : ((dir == DIR_UP) ? '0 : QMAX))
                        : ((dir == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1));

   assign q_ld  = WIDTH'(ld_clamp(32'(ld_val), MODULUS));

   assign q_nxt = clr ? '0 : (ld ? q_ld : (a ? q_step : q));

   // Flag follows the value q is about to take so both update together.
   if (THRESH == 0) begin : g_thr_zero
      assign thr_nxt = 1'b1;
   end else begin : g_thr_cmp
      assign thr_nxt = (q_nxt >= QTHR);
   end

   dffn_r #(.WIDTH(WIDTH), .RST_VAL('0)) u_q (
      .ck(ck), .rst_n(rst_n), .d(q_nxt), .q(q)
   );

   // b is already 0 under clear or load, so it alone feeds the pulse register.
   dffn_r #(.WIDTH(1), .RST_VAL(1'b0)) u_tc (
      .ck(ck), .rst_n(rst_n), .d(b), .q(tc)
   );

   dffn_r #(.WIDTH(1), .RST_VAL(THR_RST)) u_thr (
      .ck(ck), .rst_n(rst_n), .d(thr_nxt), .q(thr_hit)
   );

endmodule

// File: tb/tb_ones_cnt_modn.sv
// Bench for ones_cnt_modn: default mod-4 instance and a WIDTH=4 mod-10 instance
// driven in lockstep and compared against an integer reference model.
module tb_ones_cnt_modn;

   logic       ck;
   logic       rst_n, a, dir, sat, clr, ld;
   logic [1:0] ld_val0;
   logic [3:0] ld_val1;
   logic [1:0] q0;
   logic [3:0] q1;
   logic       b0, tc0, thr0, b1, tc1, thr1;

   int ncmp = 0;
   int nerr = 0;

   int mods[2] = '{4, 10};
   int ths[2]  = '{2, 2};
   int mq[2]   = '{0, 0};
   bit lb[2];

   ones_cnt_modn u_d0 (
      .ck(ck), .rst_n(rst_n), .a(a), .dir(dir), .sat(sat), .clr(clr), .ld(ld),
      .ld_val(ld_val0), .q(q0), .b(b0), .tc(tc0), .thr_hit(thr0)
   );

   ones_cnt_modn #(.WIDTH(4), .MODULUS(10), .THRESH(2)) u_d1 (
      .ck(ck), .rst_n(rst_n), .a(a), .dir(dir), .sat(sat), .clr(clr), .ld(ld),
      .ld_val(ld_val1), .q(q1), .b(b1), .tc(tc1), .thr_hit(thr1)
   );

   initial ck = 1'b1;
   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Counter behaviour from the rules, using modular integer arithmetic.
   function automatic void ref_step(input int m, input int th, input int cur,
                                    input bit rn, input bit ai, input bit di, input bit si,
                                    input bit ci, input bit li, input int lv,
                                    output int nq, output bit nb, output bit ntc, output bit nthr);
      bit term;
      term = di ? (cur == 0) : (cur == m - 1);
      nb   = rn && !ci && !li && ai && term;
      if (!rn || ci)        nq = 0;
      else if (li)          nq = (lv >= m) ? m - 1 : lv;
      else if (!ai)         nq = cur;
      else if (si && term)  nq = cur;
      else                  nq = di ? (cur + m - 1) % m : (cur + 1) % m;
      ntc  = (!rn || ci || li) ? 1'b0 : nb;
      nthr = (nq >= th);
   endfunction

   task automatic drv(input bit r, input bit aa, input bit d, input bit s,
                      input bit c, input bit l, input int v);
      rst_n   = r;
      a       = aa;
      dir     = d;
      sat     = s;
      clr     = c;
      ld      = l;
      ld_val0 = 2'(v);
      ld_val1 = 4'(v);
   endtask

   // One cycle: b checked mid-cycle, registered outputs just after the edge.
   task automatic step();
      int nq[2];
      bit nb[2], ntc[2], nthr[2];
      @(posedge ck);
      ref_step(mods[0], ths[0], mq[0], rst_n, a, dir, sat, clr, ld, 32'(ld_val0),
               nq[0], nb[0], ntc[0], nthr[0]);
      ref_step(mods[1], ths[1], mq[1], rst_n, a, dir, sat, clr, ld, 32'(ld_val1),
               nq[1], nb[1], ntc[1], nthr[1]);
      chk("b0", 32'(b0), 32'(nb[0]));
      chk("b1", 32'(b1), 32'(nb[1]));
      lb[0] = b0;
      lb[1] = b1;
      @(negedge ck);
      #1;
      mq[0] = nq[0];
      mq[1] = nq[1];
      chk("q0",   32'(q0),   32'(nq[0]));
      chk("tc0",  32'(tc0),  32'(ntc[0]));
      chk("thr0", 32'(thr0), 32'(nthr[0]));
      chk("q1",   32'(q1),   32'(nq[1]));
      chk("tc1",  32'(tc1),  32'(ntc[1]));
      chk("thr1", 32'(thr1), 32'(nthr[1]));
   endtask

   initial begin
      int seq[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

      drv(0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      chk("rst_q0", 32'(q0), 32'd0);
      chk("rst_thr0", 32'(thr0), 32'd0);

      // Legacy mod-4 ones counter
      drv(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         step();
         chk("seq_q0", 32'(q0), 32'(seq[i]));
      end

      // Saturating up-count on the mod-10 instance
      drv(1, 0, 0, 1, 1, 0, 0);
      step();
      drv(1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 12; i++) step();
      chk("sat_q1", 32'(q1), 32'd9);
      chk("sat_b1", 32'(lb[1]), 32'd1);

      // Down-count from 0: wrap then saturate
      drv(1, 0, 1, 0, 1, 0, 0);
      step();
      drv(1, 1, 1, 0, 0, 0, 0);
      step();
      chk("dn_b1", 32'(lb[1]), 32'd1);
      chk("dn_wrap_q1", 32'(q1), 32'd9);
      drv(1, 0, 1, 1, 1, 0, 0);
      step();
      drv(1, 1, 1, 1, 0, 0, 0);
      step();
      chk("dn_sat_q1", 32'(q1), 32'd0);

      // Load clamp, clear over load, load over event
      drv(1, 0, 0, 0, 0, 1, 13);
      step();
      chk("ld_clamp_q1", 32'(q1), 32'd9);
      drv(1, 0, 0, 0, 1, 1, 5);
      step();
      chk("clr_ld_q1", 32'(q1), 32'd0);
      drv(1, 0, 0, 0, 0, 1, 9);
      step();
      drv(1, 1, 0, 0, 0, 1, 9);
      step();
      chk("ld_a_b1", 32'(lb[1]), 32'd0);

      // Reset mid-stream
      drv(1, 0, 0, 0, 1, 0, 0);
      step();
      drv(1, 1, 0, 0, 0, 0, 0);
      step();
      step();
      drv(0, 1, 0, 0, 0, 0, 0);
      step();
      chk("mrst_q1", 32'(q1), 32'd0);
      chk("mrst_b1", 32'(lb[1]), 32'd0);
      drv(1, 1, 0, 0, 0, 0, 0);
      step();
      chk("resume_q1", 32'(q1), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drv($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 15)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/ones_cnt_modn.md
# ones_cnt_modn

Parametrised modulo-N event counter with Mealy carry/borrow output, generalising the team's 2-bit serial ones counter. Each cycle with `a`=1 steps the count up or down; a terminal-crossing event raises `b` in the same cycle. Adds clear, parallel load, wrap/saturate mode, a registered terminal pulse and a threshold flag. Sits on serial event streams feeding downstream dividers and sequence checkers.

## Interface
- `WIDTH`, 2: count register width in bits.
- `MODULUS`, 4: count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- `THRESH`, 2: compare value for `thr_hit`; must be < MODULUS.

- `ck`  in  1  clock; all state updates on the falling edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on the falling edge of `ck`.
- `a`  in  1  count event; one step per sampled 1.
- `dir`  in  1  0 = up, 1 = down.
- `sat`  in  1  0 = wrap mode, 1 = saturate mode.
- `clr`  in  1  synchronous clear.
- `ld`  in  1  synchronous parallel load.
- `ld_val`  in  WIDTH  load value.
- `q`  out  WIDTH  current count, registered.
- `b`  out  1  Mealy terminal event, combinational.
- `tc`  out  1  registered one-cycle pulse following a terminal event.
- `thr_hit`  out  1  registered; 1 when the next `q` ≥ THRESH.

## Operation
- Priority at each falling edge: `rst_n`=0 > `clr` > `ld` > `a` > hold.
- Reset: `q`=0, `tc`=0, `thr_hit`=(THRESH==0).
- `clr`: `q`←0; `tc`←0.
- `ld`: `q`←`ld_val`. If `ld_val` ≥ MODULUS, `q`←MODULUS-1 (clamp). `tc`←0.
- Count with `a`=1, `dir`=0:
  - If `q` < MODULUS-1: `q`←`q`+1.
  - If `q` = MODULUS-1: terminal. Wrap mode: `q`←0. Saturate mode: `q` holds.
- Count with `a`=1, `dir`=1:
  - If `q` > 0: `q`←`q`-1.
  - If `q` = 0: terminal. Wrap mode: `q`←MODULUS-1. Saturate mode: `q` holds at 0.
- `b` = `a` & `rst_n` & ~`clr` & ~`ld` & terminal condition. `b` is asserted in both modes.
- `tc`←`b` at every edge where reset, clear and load are all inactive.
- `thr_hit` is computed from the next-state value of `q`, so it always matches the `q` it is registered alongside.
- Arithmetic is in WIDTH bits. No intermediate value exceeds MODULUS-1, so there is no overflow beyond the modulus.
- Default configuration (WIDTH=2, MODULUS=4, `dir`=0, `sat`=0) is the legacy mod-4 ones counter: `b`=1 exactly on the fourth 1 of each group.

## Timing
- `q`, `tc`, `thr_hit` change only on the falling edge of `ck`.
- `b` is combinational from `a`, `dir`, `clr`, `ld`, `rst_n` and `q`, valid in the same cycle with zero latency. Consumers sample it on the next falling edge.
- `tc` lags `b` by exactly one edge.
- Load to visible `q`: one edge.
- Reset asserted mid-count: `q`=0 after that edge. The `a` sampled on that edge is discarded and `b` is forced 0.
- Simultaneous `clr` and `ld`: clear wins. Simultaneous `ld` and `a`: load wins and the event is lost; `b`=0.
- Changing `dir` or `sat` takes effect on the next edge with no glitch in `q`.

## Structure
- Shared package `cnt_pkg` holds:
  - constants `DIR_UP`=0, `DIR_DN`=1, `MODE_WRAP`=0, `MODE_SAT`=1;
  - a function for the clamped load value.
- Sub-module `dffn_r`: WIDTH-parametrised falling-edge D register with synchronous active-low reset and reset-value parameter. Instantiated once each for `q`, `tc` and `thr_hit`.
- Next-state and `b` logic live in `ones_cnt_modn` as continuous assigns.
- Elaboration-time checks on MODULUS and THRESH.

## Test plan
- Defaults; reset; `a`=1 for 9 edges → `q` sequence 1,2,3,0,1,2,3,0,1; `b`=1 while `q`=3 and `a`=1; `tc` pulses on the edge after each `b`.
- WIDTH=4, MODULUS=10, `sat`=1, `a`=1 for 12 edges → `q` reaches 9 and holds; `b`=1 for the last 3 cycles; `thr_hit` rises with `q`=2 (THRESH=2).
- MODULUS=10, `dir`=1, start `q`=0, `a`=1 → `b`=1 same cycle; next `q`=9 (wrap). Same stimulus with `sat`=1 → `q` stays 0.
- `ld`=1, `ld_val`=13 (WIDTH=4, MODULUS=10) → `q`=9. `ld` and `clr` together → `q`=0. `ld` and `a` together at terminal → `b`=0.
- Reset mid-stream with `q`=2 and `a`=1 → `q`=0, `b`=0, `tc`=0 after the edge; counting resumes from 0 on the next edge.
